// File: rtl/sync_param_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_param_fifo
// Brief    : Single-clock FIFO with almost-full/almost-empty thresholds,
//            occupancy count and sticky overflow/underflow flags.
//            Define FIFO_FWFT_EN for first-word-fall-through read data.
// Revision : 1.0 - initial release
// ============================================================================
module sync_param_fifo #(
    parameter int DSIZE    = 8,
    parameter int ASIZE    = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             WINC,
    input  logic [DSIZE-1:0] WDATA,
    output logic             WFULL,
    output logic             WALMOST_FULL,
    input  logic             RINC,
    output logic [DSIZE-1:0] RDATA,
    output logic             REMPTY,
    output logic             RALMOST_EMPTY,
    output logic [ASIZE:0]   COUNT,
    output logic             OVERFLOW,
    output logic             UNDERFLOW,
    input  logic             CLR_ERR
);

    localparam logic [ASIZE:0] c_one      = {{ASIZE{1'b0}}, 1'b1};
    localparam logic [ASIZE:0] c_full_xor = {1'b1, {ASIZE{1'b0}}};
    localparam logic [ASIZE:0] c_af_level = AF_LEVEL[ASIZE:0];
    localparam logic [ASIZE:0] c_ae_level = AE_LEVEL[ASIZE:0];

    logic [DSIZE-1:0] r_mem [0:(1<<ASIZE)-1];
    logic [ASIZE:0]   r_wptr, r_rptr, r_count;
    logic [ASIZE:0]   w_wptr_nxt, w_rptr_nxt, w_count_nxt;
    logic             r_wfull, r_rempty, r_walmost_full, r_ralmost_empty;
    logic             r_overflow, r_underflow;
    logic             w_wr_acc, w_rd_acc;

    assign w_wr_acc = WINC & ~r_wfull;
    assign w_rd_acc = RINC & ~r_rempty;

    always_comb begin
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_count_nxt = r_count;
        if (w_wr_acc) w_wptr_nxt = r_wptr + c_one;
        if (w_rd_acc) w_rptr_nxt = r_rptr + c_one;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + c_one;
            2'b01:   w_count_nxt = r_count - c_one;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_count         <= '0;
            r_wfull         <= 1'b0;
            r_rempty        <= 1'b1;
            r_walmost_full  <= 1'b0;
            r_ralmost_empty <= 1'b1;
            r_overflow      <= 1'b0;
            r_underflow     <= 1'b0;
        end else begin
            r_wptr          <= w_wptr_nxt;
            r_rptr          <= w_rptr_nxt;
            r_count         <= w_count_nxt;
            r_wfull         <= ((w_wptr_nxt ^ w_rptr_nxt) == c_full_xor);
            r_rempty        <= (w_wptr_nxt == w_rptr_nxt);
            r_walmost_full  <= (w_count_nxt >= c_af_level);
            r_ralmost_empty <= (w_count_nxt <= c_ae_level);
            // A new error event takes priority over a same-cycle clear
            r_overflow      <= (WINC & r_wfull)  | (r_overflow  & ~CLR_ERR);
            r_underflow     <= (RINC & r_rempty) | (r_underflow & ~CLR_ERR);
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge CLK) begin
        if (w_wr_acc) r_mem[r_wptr[ASIZE-1:0]] <= WDATA;
    end

`ifdef FIFO_FWFT_EN
    assign RDATA = r_mem[r_rptr[ASIZE-1:0]];
`else
    logic [DSIZE-1:0] r_rdata;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)        r_rdata <= '0;
        else if (w_rd_acc) r_rdata <= r_mem[r_rptr[ASIZE-1:0]];
    end

    assign RDATA = r_rdata;
`endif

    assign WFULL         = r_wfull;
    assign REMPTY        = r_rempty;
    assign WALMOST_FULL  = r_walmost_full;
    assign RALMOST_EMPTY = r_ralmost_empty;
    assign COUNT         = r_count;
    assign OVERFLOW      = r_overflow;
    assign UNDERFLOW     = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_param_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_param_fifo
// Brief    : Queue-model scoreboard bench for sync_param_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_param_fifo;

    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int AF    = 12;
    localparam int AE    = 2;
    localparam int DEPTH = 16;

    logic             CLK = 1'b0;
    logic             RST_n = 1'b1;
    logic             WINC = 1'b0, RINC = 1'b0, CLR_ERR = 1'b0;
    logic [DSIZE-1:0] WDATA = '0;
    logic [DSIZE-1:0] RDATA;
    logic             WFULL, WALMOST_FULL, REMPTY, RALMOST_EMPTY;
    logic [ASIZE:0]   COUNT;
    logic             OVERFLOW, UNDERFLOW;

    sync_param_fifo #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .WINC(WINC), .WDATA(WDATA),
        .WFULL(WFULL), .WALMOST_FULL(WALMOST_FULL), .RINC(RINC),
        .RDATA(RDATA), .REMPTY(REMPTY), .RALMOST_EMPTY(RALMOST_EMPTY),
        .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
        .CLR_ERR(CLR_ERR)
    );

    always #5 CLK = ~CLK;

    int tests  = 0;
    int failed = 0;

    logic [DSIZE-1:0] mq[$];
    logic [DSIZE-1:0] sb[$];
    logic [DSIZE-1:0] exp_last = '0;
    bit               m_ovf = 1'b0, m_udf = 1'b0;
    bit               m_full, m_empty;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored words plus sticky error bits
    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            mq.delete();
            sb.delete();
            exp_last = '0;
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
        end else begin
            m_full  = (mq.size() == DEPTH);
            m_empty = (mq.size() == 0);
            if (RINC && !m_empty) sb.push_back(mq.pop_front());
            if (WINC && !m_full)  mq.push_back(WDATA);
            m_ovf = (WINC && m_full)  || (m_ovf && !CLR_ERR);
            m_udf = (RINC && m_empty) || (m_udf && !CLR_ERR);
        end
    end

    // Monitor: compare every DUT output against the model after each edge
    always @(posedge CLK) begin
        #1;
        check("count",         COUNT,         mq.size());
        check("rempty",        REMPTY,        mq.size() == 0);
        check("wfull",         WFULL,         mq.size() == DEPTH);
        check("walmost_full",  WALMOST_FULL,  mq.size() >= AF);
        check("ralmost_empty", RALMOST_EMPTY, mq.size() <= AE);
        check("overflow",      OVERFLOW,      m_ovf);
        check("underflow",     UNDERFLOW,     m_udf);
`ifdef FIFO_FWFT_EN
        sb.delete();
        if (mq.size() > 0) check("rdata_fwft", RDATA, mq[0]);
`else
        if (sb.size() > 0) exp_last = sb.pop_front();
        check("rdata", RDATA, exp_last);
`endif
    end

    task automatic cyc(input bit w, input bit r, input logic [DSIZE-1:0] d, input bit c);
        @(negedge CLK);
        WINC    = w;
        RINC    = r;
        WDATA   = d;
        CLR_ERR = c;
    endtask

    initial begin
        #1 RST_n = 1'b0;
        repeat (3) @(negedge CLK);
        RST_n = 1'b1;
        repeat (2) cyc(0, 0, 8'h00, 0);
        check("reset_count",  COUNT, 0);
        check("reset_rempty", REMPTY, 1);
`ifndef FIFO_FWFT_EN
        check("reset_rdata",  RDATA, 8'h00);
`endif

        // Fill to full, then one rejected write
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, i[DSIZE-1:0], 0);
        cyc(0, 0, 8'h00, 0);
        check("fill_count", COUNT, 16);
        check("fill_wfull", WFULL, 1);
        cyc(1, 0, 8'hAA, 0);
        cyc(0, 0, 8'h00, 0);
        check("ovf_set", OVERFLOW, 1);

        // Drain all 16 words
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 8'h00, 0);
        cyc(0, 0, 8'h00, 1);
        check("drain_rempty", REMPTY, 1);

        // Steady state at COUNT=5 with simultaneous read/write
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'h40 + i[7:0], 0);
        for (int i = 0; i < 20; i++) cyc(1, 1, 8'h80 + i[7:0], 0);
        cyc(0, 0, 8'h00, 0);
        check("steady_count", COUNT, 5);
        check("steady_noerr", {OVERFLOW, UNDERFLOW}, 2'b00);

        // Top up to full, then simultaneous read/write while full
        for (int i = 0; i < 11; i++) cyc(1, 0, 8'hC0 + i[7:0], 0);
        cyc(1, 1, 8'hEE, 0);
        cyc(0, 0, 8'h00, 0);
        check("fullrw_count", COUNT, 15);
        check("fullrw_ovf",   OVERFLOW, 1);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0);
        check("clr_ovf", OVERFLOW, 0);

        // Drain, then simultaneous read/write while empty
        for (int i = 0; i < 15; i++) cyc(0, 1, 8'h00, 0);
        cyc(1, 1, 8'h33, 0);
        cyc(0, 0, 8'h00, 0);
        check("emptyrw_count", COUNT, 1);
        check("emptyrw_udf",   UNDERFLOW, 1);
        cyc(0, 1, 8'h00, 1);

        // Asynchronous reset in the middle of a read
        for (int i = 0; i < 3; i++) cyc(1, 0, 8'h10 + i[7:0], 0);
        cyc(0, 1, 8'h00, 0);
        #2 RST_n = 1'b0;
        #1;
        check("arst_count",  COUNT, 0);
        check("arst_rempty", REMPTY, 1);
        check("arst_ralm",   RALMOST_EMPTY, 1);
`ifndef FIFO_FWFT_EN
        check("arst_rdata",  RDATA, 8'h00);
`endif
        cyc(0, 0, 8'h00, 0);
        RST_n = 1'b1;
        cyc(1, 0, 8'h55, 0);
        cyc(0, 0, 8'h00, 0);
`ifdef FIFO_FWFT_EN
        check("post_rst_fwft", RDATA, 8'h55);
`endif
        cyc(0, 1, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);
`ifndef FIFO_FWFT_EN
        check("post_rst_rdata", RDATA, 8'h55);
`endif

        // Randomised traffic with alternating fill/drain bias
        for (int i = 0; i < 1500; i++) begin
            bit fill_phase;
            fill_phase = ((i / 100) % 2) == 0;
            cyc($urandom_range(0, 99) < (fill_phase ? 70 : 30),
                $urandom_range(0, 99) < (fill_phase ? 30 : 70),
                DSIZE'($urandom),
                $urandom_range(0, 99) < 5);
        end
        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
